data_shift_unit: RTL and testbench

- Parametrised clocked successor to the team's 2-bit data next-state logic.
- Holds a WIDTH-bit data register and applies one of eight per-cycle operations: hold, load, logical/arithmetic shift, rotate, clear.
- Adds an automatic burst mode that serialises the full register over WIDTH cycles with busy/done status.
- Sits between a parallel data source and a serial consumer in the datapath.

---
 rtl/data_shift_pkg.sv | 29 ++
 rtl/data_shift_next.sv | 49 ++++
 rtl/data_shift_unit.sv | 118 +++++++++++
 tb/tb_data_shift_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/data_shift_pkg.sv
// Shared types for the data shift unit: operation encodings, FSM states
// and a helper that identifies modes which move a bit out of the register.
package data_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True for shift, rotate and arithmetic-shift modes: these update ser_out
    // and are the only modes a burst can serialise.
    function automatic logic is_shift_mode(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/data_shift_next.sv
// Combinational next-value logic for the data register. Given the current
// value and an operation, produces the next register value and the bit that
// leaves the register (zero for modes that do not shift anything out).
module data_shift_next
    import data_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // Decode the operation into the next register value and the exiting bit.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_HOLD:  q_next = q;
            MODE_LOAD:  q_next = load_data;
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROTL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_CLEAR: q_next = '0;
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/data_shift_unit.sv
// WIDTH-bit data register with eight per-cycle operations and an automatic
// burst mode that serialises the whole register over WIDTH cycles.
// Optional macro DATA_SHIFT_PARITY_EN adds a registered parity output equal
// to the XOR reduction of q.
//
// Burst handshake: in IDLE, start=1 together with a shift/rotate/ASR mode
// launches a burst; the request is accepted on that clock edge (q untouched
// on that edge). busy is high for the following WIDTH cycles while the
// operations run, then done pulses high for exactly one cycle. start and mode
// are ignored whenever busy or done is high; there is no back-pressure.
module data_shift_unit
    import data_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
`ifdef DATA_SHIFT_PARITY_EN
    output logic             parity,
`endif
    output state_t           fsm_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    mode_t              burst_mode;
    mode_t              mode_in;
    mode_t              op;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   q_next;
    logic               out_bit;
    logic               burst_go;
    logic               apply;

    assign mode_in   = mode_t'(mode);
    assign fsm_state = state;

    // Select the operation source and decide whether it touches the register.
    always_comb begin
        op       = (state == ST_RUN) ? burst_mode : mode_in;
        burst_go = (state == ST_IDLE) && start && is_shift_mode(mode_in);
        apply    = (state == ST_RUN) || ((state == ST_IDLE) && !burst_go);
    end

    data_shift_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q        (q),
        .mode     (op),
        .ser_in   (ser_in),
        .load_data(load_data),
        .q_next   (q_next),
        .out_bit  (out_bit)
    );

    // Burst FSM, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q          <= '0;
            ser_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            state      <= ST_IDLE;
            burst_mode <= MODE_HOLD;
`ifdef DATA_SHIFT_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            if (apply) begin
                q <= q_next;
                if (is_shift_mode(op)) begin
                    ser_out <= out_bit;
                end
            end
`ifdef DATA_SHIFT_PARITY_EN
            parity <= apply ? ^q_next : ^q;
`endif
            case (state)
                ST_IDLE: begin
                    if (burst_go) begin
                        burst_mode <= mode_in;
                        count      <= CNT_W'(WIDTH);
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_shift_unit.sv
// Self-checking bench for data_shift_unit (WIDTH=8): reset, a table of
// single-cycle operations, and hand-written burst / reset-mid-burst sequences.
module tb_data_shift_unit;
    import data_shift_pkg::*;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] LOAD  = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] SHR   = 3'b011;
    localparam logic [2:0] ROTL  = 3'b100;
    localparam logic [2:0] ROTR  = 3'b101;
    localparam logic [2:0] ASR   = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] load_data;
    logic       ser_in;
    logic       start;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;
    state_t     fsm_state;
`ifdef DATA_SHIFT_PARITY_EN
    logic       parity;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard: {q, ser_out, busy, done} expected after each clock edge.
    logic [10:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [2:0] mode;
        logic [7:0] ld;
        logic       si;
        logic       st;
        logic [7:0] eq;
        logic       es;
    } vec_t;

    vec_t tbl[14];

    data_shift_unit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .load_data(load_data),
        .ser_in   (ser_in),
        .start    (start),
        .q        (q),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done),
`ifdef DATA_SHIFT_PARITY_EN
        .parity   (parity),
`endif
        .fsm_state(fsm_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compare();
        logic [10:0] got;
        logic [10:0] e;
        string       n;
        got = {q, ser_out, busy, done};
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got q=%02h ser_out=%b busy=%b done=%b, expected q=%02h ser_out=%b busy=%b done=%b",
                     n, got[10:3], got[2], got[1], got[0], e[10:3], e[2], e[1], e[0]);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [2:0] m, input logic [7:0] ld,
                        input logic si, input logic st, input logic [7:0] eq,
                        input logic es, input logic eb, input logic ed, input string nm);
        rst_n     = r;
        mode      = m;
        load_data = ld;
        ser_in    = si;
        start     = st;
        exp_q.push_back({eq, es, eb, ed});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Full burst from a register already holding init with ser_out = es0.
    // noisy: random mode and start=1 while the burst runs and in the done cycle.
    task automatic burst(input logic [2:0] bm, input logic [7:0] init, input logic es0,
                         input logic noisy, input string tag);
        logic [7:0] cur;
        logic       es;
        logic [2:0] m;
        cur = init;
        es  = es0;
        step(1'b1, bm, 8'h00, 1'b0, 1'b1, cur, es, 1'b1, 1'b0, {tag, "_start"});
        for (int k = 1; k <= 8; k++) begin
            m = noisy ? 3'($urandom_range(0, 7)) : bm;
            case (bm)
                SHR:     begin es = cur[0]; cur = {1'b0, cur[7:1]}; end
                ROTL:    begin es = cur[7]; cur = {cur[6:0], cur[7]}; end
                default: begin es = cur[0]; cur = {cur[7], cur[7:1]}; end
            endcase
            step(1'b1, m, 8'($urandom), 1'b0, noisy, cur, es, (k < 8), (k == 8),
                 $sformatf("%s_run%0d", tag, k));
        end
        // Done cycle: mode (even LOAD) and start must be ignored.
        step(1'b1, noisy ? 3'($urandom_range(2, 6)) : LOAD, 8'hFF, 1'b0, noisy,
             cur, es, 1'b0, 1'b0, {tag, "_done_cycle"});
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0, cur, es, 1'b0, 1'b0, {tag, "_idle"});
    endtask

    initial begin
        rst_n = 1'b0; mode = HOLD; load_data = 8'h00; ser_in = 1'b0; start = 1'b0;

        //            mode   ld     si    st    exp_q  exp_ser
        tbl[0]  = '{LOAD,  8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[1]  = '{SHL,   8'h00, 1'b1, 1'b0, 8'h4B, 1'b1};
        tbl[2]  = '{LOAD,  8'h80, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[3]  = '{ASR,   8'h00, 1'b1, 1'b0, 8'hC0, 1'b0};
        tbl[4]  = '{LOAD,  8'h01, 1'b0, 1'b0, 8'h01, 1'b0};
        tbl[5]  = '{ROTR,  8'h00, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[6]  = '{HOLD,  8'h55, 1'b0, 1'b0, 8'h80, 1'b1};
        tbl[7]  = '{SHR,   8'h00, 1'b0, 1'b0, 8'h40, 1'b0};
        tbl[8]  = '{ROTL,  8'h00, 1'b1, 1'b0, 8'h80, 1'b0};
        tbl[9]  = '{CLEAR, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{LOAD,  8'h12, 1'b0, 1'b0, 8'h12, 1'b0};
        tbl[11] = '{LOAD,  8'h34, 1'b0, 1'b1, 8'h34, 1'b0};
        tbl[12] = '{CLEAR, 8'h99, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[13] = '{HOLD,  8'h77, 1'b1, 1'b1, 8'h00, 1'b0};

        // Reset held for two cycles with random mode/start
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b0, 1'b0, $sformatf("reset%0d", i));
        end

        // Single-cycle operations, including start with non-shift modes
        for (int i = 0; i < 14; i++) begin
            step(1'b1, tbl[i].mode, tbl[i].ld, tbl[i].si, tbl[i].st, tbl[i].eq, tbl[i].es,
                 1'b0, 1'b0, $sformatf("op%0d", i));
        end

        // Burst SHR on 0xA5 with ser_in=0: ser_out 1,0,1,0,0,1,0,1 then q=0x00
        step(1'b1, LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, "shr_load");
        burst(SHR, 8'hA5, 1'b0, 1'b0, "shr");

        // Burst ROTL on 0x3C with noisy mode/start: q returns to 0x3C
        step(1'b1, LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, "rotl_load");
        burst(ROTL, 8'h3C, 1'b1, 1'b1, "rotl");

        // Reset on the 3rd RUN cycle of an ASR burst
        step(1'b1, LOAD, 8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, "rst_load");
        step(1'b1, ASR,  8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, "rst_start");
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, "rst_run1");
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b1, 1'b0, "rst_run2");
        step(1'b0, LOAD, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "rst_mid_burst");
        step(1'b1, HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_no_done");

        // New ASR burst after the reset: ends as all copies of the MSB
        step(1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, "asr_load");
        burst(ASR, 8'h81, 1'b0, 1'b0, "asr");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
